// File: rtl/fetch_aligner_if.sv
// rtl/fetch_aligner_if.sv - fetch-port and decode-port handshake bundle for fetch_aligner
// master drives fetch words, flush and decoder ready; slave is the aligner.
interface fetch_aligner_if;
   logic        i_flush;
   logic [31:0] i_flush_pc;
   logic        i_fetch_valid;
   logic        o_fetch_ready;
   logic [31:0] i_fetch_addr;
   logic [31:0] i_fetch_data;
   logic        o_inst_valid;
   logic        i_inst_ready;
   logic [31:0] o_inst;
   logic [31:0] o_inst_pc;
   logic        o_inst_rvc;

   modport master (
      output i_flush, i_flush_pc, i_fetch_valid, i_fetch_addr, i_fetch_data, i_inst_ready,
      input  o_fetch_ready, o_inst_valid, o_inst, o_inst_pc, o_inst_rvc
   );

   modport slave (
      input  i_flush, i_flush_pc, i_fetch_valid, i_fetch_addr, i_fetch_data, i_inst_ready,
      output o_fetch_ready, o_inst_valid, o_inst, o_inst_pc, o_inst_rvc
   );
endinterface

// File: rtl/fetch_aligner.sv
// rtl/fetch_aligner.sv - halfword realignment queue turning fetch words into RVC/32-bit instructions
// Define FETCH_BYPASS_EN to decode straight from the incoming word when the queue is empty.
module fetch_aligner #(
   parameter int          HW_DEPTH = 8,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic            i_clk,
   input logic            i_rst,
   fetch_aligner_if.slave bus
);
   localparam int PW = $clog2(HW_DEPTH);
   typedef logic [PW-1:0] ptr_t;
   typedef logic [PW:0]   cnt_t;

   logic [15:0] hw_mem [HW_DEPTH];
   logic [30:0] pc_mem [HW_DEPTH];
   ptr_t        head, tail;
   cnt_t        count;
   logic [29:0] exp_addr;
   logic        skip_lo;

   logic        accept, push, use_bypass;
   logic [15:0] inc_hw [2];
   logic [30:0] inc_pc [2];
   logic [1:0]  inc_n;
   ptr_t        head_p1, tail_p1;
   logic [15:0] d_hw0, d_hw1;
   logic [30:0] d_pc0;
   logic        ge1, ge2, rvc, valid, pop;
   logic [1:0]  pop_n, wr_skip, wr_n, head_adv;
   logic        unused_bits;

   assign unused_bits = ^{bus.i_fetch_addr[1:0], bus.i_flush_pc[0]};

   assign bus.o_fetch_ready = (count <= cnt_t'(HW_DEPTH - 2)) && !bus.i_flush;
   assign accept = bus.i_fetch_valid && bus.o_fetch_ready;
   // A word off the expected address is stale (pre-redirect) and is swallowed without effect.
   assign push   = accept && (bus.i_fetch_addr[31:2] == exp_addr);

   always_comb begin
      inc_hw[0] = skip_lo ? bus.i_fetch_data[31:16] : bus.i_fetch_data[15:0];
      inc_hw[1] = bus.i_fetch_data[31:16];
      inc_pc[0] = {bus.i_fetch_addr[31:2], skip_lo};
      inc_pc[1] = {bus.i_fetch_addr[31:2], 1'b1};
      inc_n     = !push ? 2'd0 : (skip_lo ? 2'd1 : 2'd2);
   end

`ifdef FETCH_BYPASS_EN
   assign use_bypass = push && (count == '0);
`else
   assign use_bypass = 1'b0;
`endif

   assign head_p1 = head + 1'b1;
   assign tail_p1 = tail + 1'b1;

   always_comb begin
      d_hw0 = hw_mem[head];
      d_hw1 = hw_mem[head_p1];
      d_pc0 = pc_mem[head];
      ge1   = (count != '0);
      ge2   = (count > cnt_t'(1));
      if (use_bypass) begin
         d_hw0 = inc_hw[0];
         d_hw1 = inc_hw[1];
         d_pc0 = inc_pc[0];
         ge1   = 1'b1;
         ge2   = (inc_n == 2'd2);
      end
   end

   assign rvc   = (d_hw0[1:0] != 2'b11);
   assign valid = !bus.i_flush && ((ge1 && rvc) || ge2);
   assign pop   = valid && bus.i_inst_ready;
   assign pop_n = rvc ? 2'd1 : 2'd2;

   assign bus.o_inst_valid = valid;
   assign bus.o_inst       = valid ? (rvc ? {16'h0000, d_hw0} : {d_hw1, d_hw0}) : 32'h0;
   assign bus.o_inst_pc    = valid ? {d_pc0, 1'b0} : 32'h0;
   assign bus.o_inst_rvc   = valid && rvc;

   // Bypassed halfwords consumed this cycle are never written; only the remainder lands at tail.
   assign wr_skip  = (use_bypass && pop) ? pop_n : 2'd0;
   assign wr_n     = inc_n - wr_skip;
   assign head_adv = (pop && !use_bypass) ? pop_n : 2'd0;

   always_ff @(posedge i_clk) begin
      if (wr_n != 2'd0) begin
         hw_mem[tail] <= inc_hw[wr_skip[0]];
         pc_mem[tail] <= inc_pc[wr_skip[0]];
      end
      if (wr_n == 2'd2) begin
         hw_mem[tail_p1] <= inc_hw[1];
         pc_mem[tail_p1] <= inc_pc[1];
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         exp_addr <= RESET_PC[31:2];
         skip_lo  <= RESET_PC[1];
      end else if (bus.i_flush) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         exp_addr <= bus.i_flush_pc[31:2];
         skip_lo  <= bus.i_flush_pc[1];
      end else begin
         tail  <= tail + ptr_t'(wr_n);
         head  <= head + ptr_t'(head_adv);
         count <= count + cnt_t'(wr_n) - cnt_t'(head_adv);
         if (push) begin
            exp_addr <= exp_addr + 30'd1;
            skip_lo  <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_fetch_aligner.sv
// tb/tb_fetch_aligner.sv - self-checking bench for fetch_aligner
// Vector table for the basic flow, scoreboard queue for flush, fill/wrap and reset sequences.
module tb_fetch_aligner;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fetch_aligner_if bus ();

   fetch_aligner #(.HW_DEPTH(8), .RESET_PC(32'h0)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.slave)
   );

   typedef struct {
      logic        fv;
      logic [31:0] addr;
      logic [31:0] data;
      logic        rdy;
      logic        e_fr;
      logic        e_iv;
      logic [31:0] e_inst;
      logic [31:0] e_pc;
      logic        e_rvc;
   } vec_t;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        rvc;
   } exp_t;

   exp_t sbq [$];
   int   n_cmp = 0;
   int   n_fail = 0;
   bit   sb_on = 1'b0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic vec_t mk(logic fv, logic [31:0] addr, logic [31:0] data, logic rdy,
                               logic e_fr, logic e_iv, logic [31:0] e_inst,
                               logic [31:0] e_pc, logic e_rvc);
      vec_t v;
      v.fv = fv; v.addr = addr; v.data = data; v.rdy = rdy;
      v.e_fr = e_fr; v.e_iv = e_iv; v.e_inst = e_inst; v.e_pc = e_pc; v.e_rvc = e_rvc;
      return v;
   endfunction

   task automatic drive(logic fl, logic [31:0] fpc, logic fv, logic [31:0] addr,
                        logic [31:0] data, logic rdy);
      bus.i_flush       = fl;
      bus.i_flush_pc    = fpc;
      bus.i_fetch_valid = fv;
      bus.i_fetch_addr  = addr;
      bus.i_fetch_data  = data;
      bus.i_inst_ready  = rdy;
   endtask

   task automatic settle();
      exp_t e;
      @(negedge clk);
      if (sb_on && bus.o_inst_valid && bus.i_inst_ready) begin
         if (sbq.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL sb_unexpected: got inst %h pc %h expected none", bus.o_inst, bus.o_inst_pc);
         end else begin
            e = sbq.pop_front();
            chk("sb_inst", bus.o_inst, e.inst);
            chk("sb_pc", bus.o_inst_pc, e.pc);
            chk("sb_rvc", {31'd0, bus.o_inst_rvc}, {31'd0, e.rvc});
         end
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(string name);
      drive(0, 0, 0, 0, 0, 1);
      for (int c = 0; c < 20 && sbq.size() != 0; c++) begin
         settle();
         adv();
      end
      chk(name, sbq.size(), 0);
   endtask

   function automatic exp_t ex(logic [31:0] inst, logic [31:0] pc, logic rvc);
      exp_t e;
      e.inst = inst; e.pc = pc; e.rvc = rvc;
      return e;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vt [14];
      logic [31:0] base;
      logic [31:0] d;

      vt[0]  = mk(0, 32'h0, 32'h0,         0, 1, 0, 32'h0,        32'h0, 0);
      vt[1]  = mk(1, 32'h0, 32'h0000_0013, 0, 1, 0, 32'h0,        32'h0, 0);
      vt[2]  = mk(0, 32'h0, 32'h0,         1, 1, 1, 32'h0000_0013, 32'h0, 0);
      vt[3]  = mk(1, 32'h4, 32'h4501_4501, 1, 1, 0, 32'h0,        32'h0, 0);
      vt[4]  = mk(0, 32'h0, 32'h0,         1, 1, 1, 32'h0000_4501, 32'h4, 1);
      vt[5]  = mk(0, 32'h0, 32'h0,         1, 1, 1, 32'h0000_4501, 32'h6, 1);
      vt[6]  = mk(0, 32'h0, 32'h0,         1, 1, 0, 32'h0,        32'h0, 0);
      vt[7]  = mk(1, 32'h8, 32'h0013_4505, 1, 1, 0, 32'h0,        32'h0, 0);
      vt[8]  = mk(0, 32'h0, 32'h0,         1, 1, 1, 32'h0000_4505, 32'h8, 1);
      vt[9]  = mk(0, 32'h0, 32'h0,         1, 1, 0, 32'h0,        32'h0, 0);
      vt[10] = mk(1, 32'hC, 32'hABCD_0000, 1, 1, 0, 32'h0,        32'h0, 0);
      vt[11] = mk(0, 32'h0, 32'h0,         1, 1, 1, 32'h0000_0013, 32'hA, 0);
      vt[12] = mk(0, 32'h0, 32'h0,         1, 1, 1, 32'h0000_ABCD, 32'hE, 1);
      vt[13] = mk(0, 32'h0, 32'h0,         1, 1, 0, 32'h0,        32'h0, 0);

      drive(0, 0, 0, 0, 0, 0);
      #1;
      chk("rst_fetch_ready", {31'd0, bus.o_fetch_ready}, 32'd1);
      chk("rst_inst_valid", {31'd0, bus.o_inst_valid}, 32'd0);
      chk("rst_inst", bus.o_inst, 32'h0);
      adv();
      rst = 1'b0;

      for (int i = 0; i < 14; i++) begin
         drive(0, 0, vt[i].fv, vt[i].addr, vt[i].data, vt[i].rdy);
         settle();
         chk($sformatf("row%0d_fetch_ready", i), {31'd0, bus.o_fetch_ready}, {31'd0, vt[i].e_fr});
         chk($sformatf("row%0d_inst_valid", i), {31'd0, bus.o_inst_valid}, {31'd0, vt[i].e_iv});
         chk($sformatf("row%0d_inst", i), bus.o_inst, vt[i].e_inst);
         chk($sformatf("row%0d_pc", i), bus.o_inst_pc, vt[i].e_pc);
         chk($sformatf("row%0d_rvc", i), {31'd0, bus.o_inst_rvc}, {31'd0, vt[i].e_rvc});
         adv();
      end

      // flush with fetch and decode both active: queued word must vanish
      drive(0, 0, 1, 32'h10, 32'h0000_0013, 0);
      settle(); adv();
      drive(1, 32'h102, 1, 32'h14, 32'h0000_0093, 1);
      settle();
      chk("flush_inst_valid", {31'd0, bus.o_inst_valid}, 32'd0);
      chk("flush_fetch_ready", {31'd0, bus.o_fetch_ready}, 32'd0);
      adv();
      drive(0, 0, 0, 0, 0, 1);
      settle();
      chk("post_flush_empty", {31'd0, bus.o_inst_valid}, 32'd0);
      chk("post_flush_ready", {31'd0, bus.o_fetch_ready}, 32'd1);
      adv();
      drive(0, 0, 1, 32'h8, 32'h1234_5678, 1);
      settle(); adv();
      drive(0, 0, 0, 0, 0, 1);
      settle();
      chk("stale_dropped", {31'd0, bus.o_inst_valid}, 32'd0);
      adv();
      drive(0, 0, 1, 32'h100, 32'h0013_4501, 1);
      settle(); adv();
      drive(0, 0, 0, 0, 0, 1);
      settle();
      chk("skip_lo_waits", {31'd0, bus.o_inst_valid}, 32'd0);
      adv();
      sb_on = 1'b1;
      sbq.push_back(ex(32'h0000_0013, 32'h102, 0));
      sbq.push_back(ex(32'h0000_DEAD, 32'h106, 1));
      drive(0, 0, 1, 32'h104, 32'hDEAD_0000, 1);
      settle(); adv();
      drain("flush_drained");

      // three fills of 32-bit instructions starting at an odd head so pointers wrap
      base = 32'h108;
      for (int f = 0; f < 3; f++) begin
         for (int k = 0; k < 4; k++) begin
            d = 32'h0000_0013 | (32'(f * 4 + k + 1) << 7);
            sbq.push_back(ex(d, base, 0));
            drive(0, 0, 1, base, d, 0);
            settle(); adv();
            base = base + 32'd4;
         end
         drive(0, 0, 0, 0, 0, 0);
         settle();
         chk($sformatf("fill%0d_full", f), {31'd0, bus.o_fetch_ready}, 32'd0);
         chk($sformatf("fill%0d_valid", f), {31'd0, bus.o_inst_valid}, 32'd1);
         adv();
         drive(0, 0, 0, 0, 0, 1);
         settle(); adv();
         drive(0, 0, 0, 0, 0, 0);
         settle();
         chk($sformatf("fill%0d_ready_after_pop", f), {31'd0, bus.o_fetch_ready}, 32'd1);
         adv();
         drain($sformatf("fill%0d_drained", f));
      end

      // asynchronous reset with an instruction pending
      sb_on = 1'b0;
      drive(0, 0, 1, base, 32'h0000_0013, 0);
      settle(); adv();
      drive(0, 0, 0, 0, 0, 0);
      settle();
      chk("pre_rst_valid", {31'd0, bus.o_inst_valid}, 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_valid", {31'd0, bus.o_inst_valid}, 32'd0);
      chk("mid_rst_fetch_ready", {31'd0, bus.o_fetch_ready}, 32'd1);
      chk("mid_rst_inst", bus.o_inst, 32'h0);
      chk("mid_rst_pc", bus.o_inst_pc, 32'h0);
      chk("mid_rst_rvc", {31'd0, bus.o_inst_rvc}, 32'd0);
      adv();
      rst = 1'b0;
      drive(0, 0, 1, 32'h0, 32'h0000_0093, 0);
      settle(); adv();
      drive(0, 0, 0, 0, 0, 0);
      settle();
      chk("post_rst_valid", {31'd0, bus.o_inst_valid}, 32'd1);
      chk("post_rst_inst", bus.o_inst, 32'h0000_0093);
      chk("post_rst_pc", bus.o_inst_pc, 32'h0);
      adv();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
